// File: rtl/fifo_ram_ctrl.sv
// fifo_ram_ctrl
// Turns a 64x8 dual-port RAM into a synchronous FIFO. The RAM's port A is
// write-only and port B is read-only. This block holds the pointers, the
// occupancy-derived status, and the sticky error flags.
//
// Ports
//   clk, rst              rising-edge clock; asynchronous active-high reset
//   flush                 synchronous clear (pointers, pop_valid, error flags)
//   push, push_data       enqueue request and data
//   full, almost_full     count == DEPTH, count >= AF_LEVEL
//   pop                   dequeue request
//   pop_data, pop_valid   RAM port-B data and its one-cycle qualifier
//   empty, count          count == 0, occupancy 0..DEPTH
//   ovf_err, udf_err      sticky push-while-full / pop-while-empty flags
//   ram_*_a               RAM write port (address, data, write enable)
//   ram_*_b, ram_q_b      RAM read port (address, tied-off data/we, read data)
module fifo_ram_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int AF_LEVEL = 56
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              almost_full,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf_err,
  output logic              udf_err,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic              ram_we_a,
  output logic [DATA_W-1:0] ram_data_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AF_CNT  = (ADDR_W+1)'(AF_LEVEL);

  // One extra MSB on each pointer distinguishes full from empty when the
  // low (address) bits coincide.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            push_acc;
  logic            pop_acc;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                       (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AF_CNT);

  // Acceptance uses pre-edge full/empty, so a push into a full FIFO is
  // refused even when a pop frees a slot on the same edge (and vice versa).
  assign push_acc = push & ~full & ~flush;
  assign pop_acc  = pop & ~empty & ~flush;

  assign ram_we_a   = push_acc;
  assign ram_addr_a = wr_ptr[ADDR_W-1:0];
  assign ram_data_a = push_data;
  assign ram_addr_b = rd_ptr[ADDR_W-1:0];
  assign ram_data_b = '0;
  assign ram_we_b   = 1'b0;

  // The RAM registers ram[rd_ptr] on the pop edge, so its output lines up
  // with pop_valid one cycle later.
  assign pop_data = ram_q_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pop_valid <= 1'b0;
      ovf_err   <= 1'b0;
      udf_err   <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pop_valid <= 1'b0;
      ovf_err   <= 1'b0;
      udf_err   <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
      pop_valid <= pop_acc;
      if (push && full) ovf_err <= 1'b1;
      if (pop && empty) udf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
module tb_fifo_ram_ctrl;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       push;
  logic [7:0] push_data;
  logic       full;
  logic       almost_full;
  logic       pop;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic       empty;
  logic [6:0] count;
  logic       ovf_err;
  logic       udf_err;
  logic [7:0] ram_data_a;
  logic [5:0] ram_addr_a;
  logic       ram_we_a;
  logic [7:0] ram_data_b;
  logic [5:0] ram_addr_b;
  logic       ram_we_b;
  logic [7:0] ram_q_b;

  fifo_ram_ctrl #(.DATA_W(8), .ADDR_W(6), .AF_LEVEL(56)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push(push), .push_data(push_data), .full(full), .almost_full(almost_full),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .empty(empty),
    .count(count), .ovf_err(ovf_err), .udf_err(udf_err),
    .ram_data_a(ram_data_a), .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a),
    .ram_data_b(ram_data_b), .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b),
    .ram_q_b(ram_q_b)
  );

  // 64x8 dual-port RAM with a registered port-B read
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_b <= mem[ram_addr_b];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every status output against the expected count and flags.
  task automatic chk_status(input string tag, input int e_count, input bit e_pv,
                            input int e_data, input bit e_ovf, input bit e_udf);
    chk({tag, "_count"}, int'(count), e_count);
    chk({tag, "_empty"}, int'(empty), int'(e_count == 0));
    chk({tag, "_full"}, int'(full), int'(e_count == 64));
    chk({tag, "_afull"}, int'(almost_full), int'(e_count >= 56));
    chk({tag, "_pop_valid"}, int'(pop_valid), int'(e_pv));
    if (e_pv) chk({tag, "_pop_data"}, int'(pop_data), e_data);
    chk({tag, "_ovf"}, int'(ovf_err), int'(e_ovf));
    chk({tag, "_udf"}, int'(udf_err), int'(e_udf));
  endtask

  typedef struct {
    bit       push;
    bit       pop;
    bit       flush;
    bit [7:0] data;
    bit       e_we;
    int       e_count;
    bit       e_pv;
    int       e_data;
    bit       e_ovf;
    bit       e_udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit p, bit pp, bit f, bit [7:0] d, bit we, int c,
                              bit pv, int pd, bit o, bit u);
    vec_t v;
    v.push = p; v.pop = pp; v.flush = f; v.data = d; v.e_we = we;
    v.e_count = c; v.e_pv = pv; v.e_data = pd; v.e_ovf = o; v.e_udf = u;
    return v;
  endfunction

  // Queue model for the longer hand-written sequences
  logic [7:0] mq[$];
  bit m_ovf, m_udf;

  // Drive one cycle, check the write enable before the edge and all status
  // after it, keeping the queue model in step.
  task automatic op(input string tag, input bit p, input bit pp, input bit f,
                    input logic [7:0] d);
    bit   push_ok, pop_ok, pv;
    int   exp_d;
    push = p; pop = pp; flush = f; push_data = d;
    push_ok = p && (mq.size() < 64) && !f;
    pop_ok  = pp && (mq.size() > 0) && !f;
    #1;
    chk({tag, "_we_a"}, int'(ram_we_a), int'(push_ok));
    exp_d = 0;
    pv = 1'b0;
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (p && mq.size() == 64) m_ovf = 1'b1;
      if (pp && mq.size() == 0) m_udf = 1'b1;
      if (pop_ok) begin
        exp_d = int'(mq.pop_front());
        pv = 1'b1;
      end
      if (push_ok) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    chk_status(tag, mq.size(), pv, exp_d, m_ovf, m_udf);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; push_data = 8'h00;
    for (int i = 0; i < 64; i++) mem[i] = 8'hC3;
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 0, 1'b0, 0, 1'b0, 1'b0);
    chk("reset_addr_a", int'(ram_addr_a), 0);
    chk("reset_addr_b", int'(ram_addr_b), 0);
    chk("reset_we_b", int'(ram_we_b), 0);
    rst = 1'b0;

    // Directed vectors: push/pop/flush -> expected status after the edge
    vecs.push_back(mk(1, 0, 0, 8'h33, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h44, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h55, 1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 2, 1, 8'h33, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, 1, 8'h44, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 8'h55, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    // pop on empty together with push: pop refused, push taken
    vecs.push_back(mk(1, 1, 0, 8'hA5, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 8'hA5, 0, 1));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 0, 0, 8'(8'h10 + i), 1, i + 1, 0, 0, 0, 1));
    // flush wins over push and pop
    vecs.push_back(mk(1, 1, 1, 8'hEE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h77, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 8'h77, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      push = vecs[i].push; pop = vecs[i].pop; flush = vecs[i].flush;
      push_data = vecs[i].data;
      #1;
      chk($sformatf("vec%0d_we_a", i), int'(ram_we_a), int'(vecs[i].e_we));
      @(posedge clk);
      #1;
      chk_status($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_pv,
                 vecs[i].e_data, vecs[i].e_ovf, vecs[i].e_udf);
    end

    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;

    // Fill to 64, overflow attempt, push+pop while full, then drain in order
    for (int i = 0; i < 64; i++) op($sformatf("fill%0d", i), 1, 0, 0, 8'(i));
    op("ovf_push", 1, 0, 0, 8'hFF);
    op("ovf_pushpop", 1, 1, 0, 8'hFE);
    for (int i = 0; i < 63; i++) op($sformatf("drain%0d", i), 0, 1, 0, 8'h00);
    op("drain_idle", 0, 0, 0, 8'h00);

    // Hold at 60 with simultaneous push/pop; pointers wrap past 63
    op("flush_a", 0, 0, 1, 8'h00);
    for (int i = 0; i < 60; i++) op($sformatf("pre%0d", i), 1, 0, 0, 8'(i));
    for (int i = 0; i < 100; i++)
      op($sformatf("steady%0d", i), 1, 1, 0, 8'(60 + i));
    for (int i = 0; i < 60; i++) op($sformatf("post%0d", i), 0, 1, 0, 8'h00);

    // Asynchronous reset mid-burst with pop_valid and udf_err both set
    op("udf_set", 0, 1, 0, 8'h00);
    for (int i = 0; i < 20; i++) op($sformatf("burst%0d", i), 1, 0, 0, 8'(8'h40 + i));
    push = 1'b1; pop = 1'b1; push_data = 8'h99;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_status("async_rst", 0, 1'b0, 0, 1'b0, 1'b0);
    chk("async_rst_addr_a", int'(ram_addr_a), 0);
    chk("async_rst_addr_b", int'(ram_addr_b), 0);
    push = 1'b0; pop = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    op("resume_push", 1, 0, 0, 8'h5A);
    op("resume_pop", 0, 1, 0, 8'h00);
    op("resume_idle", 0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
